// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the iterative shift unit: operation encodings and the
// control FSM state type. Imported by the interface users, the step datapath
// and the top.
// -----------------------------------------------------------------------------
package shift_pkg;

  // Operation encodings carried on the 2-bit op field.
  localparam logic [1:0] OP_SLL  = 2'b00;  // logical left, zero fill at LSBs
  localparam logic [1:0] OP_SRL  = 2'b01;  // logical right, zero fill at MSBs
  localparam logic [1:0] OP_SRA  = 2'b10;  // arithmetic right, sign fill
  localparam logic [1:0] OP_ROTR = 2'b11;  // rotate right, LSBs wrap to MSBs

  // Control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage : shift_pkg

// File: rtl/shift_unit_iterative_if.sv
// -----------------------------------------------------------------------------
// shift_unit_iterative_if
// Request/response bundle between the datapath control and the shift unit.
//   start    : request, only honoured while the unit is idle
//   op       : operation select (see shift_pkg OP_* encodings)
//   data_in  : operand, captured on an accepted start
//   shamt    : shift amount, captured on an accepted start
//   busy     : unit is iterating; requester must stall
//   done     : one-cycle pulse, data_out carries the result
//   data_out : result, stable from done until the next accepted start
// Modports:
//   master : requester side (drives start/op/data_in/shamt)
//   slave  : shift unit side (drives busy/done/data_out)
// -----------------------------------------------------------------------------
interface shift_unit_iterative_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
);

  logic                   start;
  logic [1:0]             op;
  logic [DATA_WIDTH-1:0]  data_in;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   busy;
  logic                   done;
  logic [DATA_WIDTH-1:0]  data_out;

  modport master (
    output start,
    output op,
    output data_in,
    output shamt,
    input  busy,
    input  done,
    input  data_out
  );

  modport slave (
    input  start,
    input  op,
    input  data_in,
    input  shamt,
    output busy,
    output done,
    output data_out
  );

endinterface : shift_unit_iterative_if

// File: rtl/shift_step_comb.sv
// -----------------------------------------------------------------------------
// shift_step_comb
// Purely combinational single-iteration shifter. Shifts acc by k positions
// according to op. The caller guarantees k never exceeds the per-cycle step
// size, so the synthesised shifter only needs to cover 0..STEP in practice.
// Ports:
//   acc : DATA_WIDTH  value being shifted
//   op  : 2           operation select (shift_pkg OP_*)
//   k   : K_WIDTH     shift distance for this iteration
//   res : DATA_WIDTH  shifted value
// -----------------------------------------------------------------------------
module shift_step_comb
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int K_WIDTH    = 5
) (
  input  logic [DATA_WIDTH-1:0] acc,
  input  logic [1:0]            op,
  input  logic [K_WIDTH-1:0]    k,
  output logic [DATA_WIDTH-1:0] res
);

  // Select the shifted value for the requested operation.
  always_comb begin
    res = acc;
    case (op)
      OP_SLL:  res = acc << k;
      OP_SRL:  res = acc >> k;
      // Arithmetic shift always refills from the current MSB; since that bit
      // is itself a copy of the original sign, the sign survives every step.
      OP_SRA:  res = $unsigned($signed(acc) >>> k);
      // For k == 0 the left term shifts by the full width and vanishes,
      // leaving acc unchanged, which is the correct rotate-by-zero.
      OP_ROTR: res = (acc >> k) | (acc << (DATA_WIDTH - int'(k)));
      default: res = acc;
    endcase
  end

endmodule : shift_step_comb

// File: rtl/shift_unit_iterative.sv
// -----------------------------------------------------------------------------
// shift_unit_iterative
// Multi-cycle SLL/SRL/SRA/ROTR unit for the MIPS datapath. Shifts at most
// STEP positions per clock, so a shift by shamt completes ceil(shamt/STEP)
// iterations after acceptance, plus one cycle to present the result.
// Timing (start accepted at cycle 0):
//   shamt == 0 : done at cycle 1, busy never asserted
//   shamt  > 0 : busy for cycles 1..ceil(shamt/STEP), done at the next cycle
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; aborts any operation without a done
//   bus   : shift_unit_iterative_if.slave (start/op/data_in/shamt in,
//           busy/done/data_out out)
// -----------------------------------------------------------------------------
module shift_unit_iterative
  import shift_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5,
  parameter int STEP        = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  shift_unit_iterative_if.slave  bus
);

  state_t                 state_r;
  logic [DATA_WIDTH-1:0]  acc_r;
  logic [SHAMT_WIDTH-1:0] remaining_r;
  logic [1:0]             op_r;
  logic                   busy_r;
  logic                   done_r;
  logic [DATA_WIDTH-1:0]  data_out_r;

  logic [SHAMT_WIDTH-1:0] k_s;
  logic [SHAMT_WIDTH-1:0] remaining_next_s;
  logic [DATA_WIDTH-1:0]  step_res_s;

  // Distance for this iteration: min(STEP, remaining), and what is left after.
  always_comb begin
    k_s              = remaining_r;
    remaining_next_s = '0;
    if (int'(remaining_r) > STEP) begin
      k_s = SHAMT_WIDTH'(STEP);
    end else begin
      k_s = remaining_r;
    end
    remaining_next_s = remaining_r - k_s;
  end

  shift_step_comb #(
    .DATA_WIDTH (DATA_WIDTH),
    .K_WIDTH    (SHAMT_WIDTH)
  ) u_step (
    .acc (acc_r),
    .op  (op_r),
    .k   (k_s),
    .res (step_res_s)
  );

  // Control FSM with registered busy/done/data_out.
  // The result is loaded into data_out on the edge that enters FINISH so that
  // it is already valid while done is high during the FINISH cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      acc_r       <= '0;
      remaining_r <= '0;
      op_r        <= 2'b00;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      data_out_r  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          busy_r <= 1'b0;
          if (bus.start) begin
            acc_r       <= bus.data_in;
            remaining_r <= bus.shamt;
            op_r        <= bus.op;
            if (bus.shamt == '0) begin
              // Nothing to shift: the operand is the result.
              state_r    <= ST_FINISH;
              done_r     <= 1'b1;
              data_out_r <= bus.data_in;
            end else begin
              state_r <= ST_SHIFT;
              busy_r  <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_SHIFT: begin
          acc_r       <= step_res_s;
          remaining_r <= remaining_next_s;
          if (remaining_next_s == '0) begin
            // Last iteration: publish the result and drop busy so that done
            // and busy are never high in the same cycle.
            state_r    <= ST_FINISH;
            busy_r     <= 1'b0;
            done_r     <= 1'b1;
            data_out_r <= step_res_s;
          end else begin
            state_r <= ST_SHIFT;
            busy_r  <= 1'b1;
          end
        end

        ST_FINISH: begin
          // Any start seen here is dropped; the requester retries in IDLE.
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end

        default: begin
          state_r <= ST_IDLE;
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.data_out = data_out_r;

endmodule : shift_unit_iterative

// File: tb/tb_shift_unit_iterative.sv
// -----------------------------------------------------------------------------
// tb_shift_unit_iterative
// Scoreboard bench for shift_unit_iterative (DATA_WIDTH=32, SHAMT_WIDTH=5,
// STEP=4). The driver pushes the expected result, latency and busy length
// for every accepted request; an independent monitor pops and compares on
// each done pulse and checks the done/busy/data_out invariants every cycle.
// -----------------------------------------------------------------------------
module tb_shift_unit_iterative;
  import shift_pkg::*;

  localparam int DW   = 32;
  localparam int SW   = 5;
  localparam int STEP = 4;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [31:0] data;
    int          lat;
    int          busy_cycles;
    int          start_cyc;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] last_result = 32'h0;

  shift_unit_iterative_if #(.DATA_WIDTH(DW), .SHAMT_WIDTH(SW)) bus ();

  shift_unit_iterative #(
    .DATA_WIDTH  (DW),
    .SHAMT_WIDTH (SW),
    .STEP        (STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Bit-level definition of each operation: output bit i is taken from the
  // input bit it must come from after a shift of s, or from the fill value.
  function automatic logic [31:0] ref_model(input logic [1:0] op, input logic [31:0] d, input int s);
    logic [31:0] r;
    r = 32'h0;
    for (int i = 0; i < 32; i++) begin
      case (op)
        OP_SLL:  r[i] = (i >= s)     ? d[(i - s) & 31] : 1'b0;
        OP_SRL:  r[i] = (i + s < 32) ? d[(i + s) & 31] : 1'b0;
        OP_SRA:  r[i] = (i + s < 32) ? d[(i + s) & 31] : d[31];
        default: r[i] = d[(i + s) % 32];
      endcase
    end
    return r;
  endfunction

  // Drive one start pulse; optionally record what the DUT owes us for it.
  task automatic issue(input logic [1:0] op, input logic [31:0] d, input logic [4:0] s,
                       input logic [31:0] exp_data, input bit push);
    exp_t e;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.data_in = d;
    bus.shamt   = s;
    if (push) begin
      e.data        = exp_data;
      e.lat         = 1 + ceil_div(int'(s), STEP);
      e.busy_cycles = ceil_div(int'(s), STEP);
      e.start_cyc   = cyc;
      sb_q.push_back(e);
    end
    @(negedge clk);
    // Scramble the inputs so any mid-operation re-sampling shows up.
    bus.start   = 1'b0;
    bus.op      = 2'($urandom_range(0, 3));
    bus.data_in = $urandom();
    bus.shamt   = 5'($urandom_range(0, 31));
  endtask

  // Return at the negedge where done is high, or flag a timeout.
  task automatic wait_done(input string name);
    int budget;
    budget = 0;
    while (!bus.done && budget < 40) begin
      @(negedge clk);
      budget++;
    end
    if (!bus.done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 40 cycles, expected a done pulse", name);
    end
  endtask

  // Monitor: scoreboard compare on done, invariant checks every cycle.
  initial begin
    exp_t e;
    int   busy_cnt;
    logic prev_done;
    busy_cnt  = 0;
    prev_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.done) begin
        chk("done_busy_exclusive", {31'h0, bus.busy}, 32'h0);
        chk("done_single_cycle", {31'h0, prev_done}, 32'h0);
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 with data_out 0x%08h, expected no pending result", bus.data_out);
        end else begin
          e = sb_q.pop_front();
          chk("data_out", bus.data_out, e.data);
          chk("latency", 32'(cyc - e.start_cyc), 32'(e.lat));
          chk("busy_cycles", 32'(busy_cnt), 32'(e.busy_cycles));
          last_result = e.data;
        end
        busy_cnt = 0;
      end else if (bus.busy) begin
        chk("data_out_hold", bus.data_out, last_result);
        busy_cnt++;
      end
      prev_done = bus.done;
      if (reset) begin
        last_result = 32'h0;
        busy_cnt    = 0;
      end
    end
  end

  // Stimulus.
  initial begin
    logic [1:0]  r_op;
    logic [31:0] r_d;
    logic [4:0]  r_s;
    int          guard;

    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.op      = OP_SLL;
    bus.data_in = 32'h0;
    bus.shamt   = 5'd0;
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_done", {31'h0, bus.done}, 32'h0);
    chk("reset_data_out", bus.data_out, 32'h0);
    reset = 1'b0;

    // Directed cases with hand-derived results.
    issue(OP_SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b1);
    wait_done("sll31");
    issue(OP_SRA, 32'hF000_0000, 5'd6, 32'hFFC0_0000, 1'b1);
    wait_done("sra6");
    issue(OP_SRL, 32'hF000_0000, 5'd6, 32'h03C0_0000, 1'b1);
    wait_done("srl6");
    issue(OP_ROTR, 32'h1234_5678, 5'd4, 32'h8123_4567, 1'b1);
    wait_done("rotr4");
    for (int o = 0; o < 4; o++) begin
      issue(2'(o), 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);
      wait_done("shamt0");
    end
    issue(OP_SRA, 32'h8000_0001, 5'd5, 32'hFC00_0000, 1'b1);
    wait_done("sra5_odd");

    // Start held high with other operands for the whole operation, FINISH included.
    issue(OP_SLL, 32'h0000_0003, 5'd20, 32'h0030_0000, 1'b1);
    bus.start   = 1'b1;
    bus.op      = OP_SRL;
    bus.data_in = 32'hA5A5_A5A5;
    bus.shamt   = 5'd1;
    wait_done("ignore_busy");
    @(negedge clk);
    bus.start = 1'b0;
    chk("finish_start_ignored", {31'h0, bus.busy}, 32'h0);
    @(negedge clk);
    chk("finish_start_no_done", {31'h0, bus.done}, 32'h0);

    // Reset in the middle of SHIFT: abort, outputs cleared, no done afterwards.
    issue(OP_SLL, 32'hFFFF_FFFF, 5'd31, 32'h0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    chk("abort_data_out", bus.data_out, 32'h0);
    repeat (12) @(negedge clk);

    // Reset and start together: reset wins, nothing is accepted.
    issue(OP_ROTR, 32'h0000_000F, 5'd4, 32'hF000_0000, 1'b1);
    wait_done("rotr_before_reset");
    @(negedge clk);
    reset       = 1'b1;
    bus.start   = 1'b1;
    bus.op      = OP_SLL;
    bus.data_in = 32'h1111_1111;
    bus.shamt   = 5'd3;
    @(negedge clk);
    reset     = 1'b0;
    bus.start = 1'b0;
    chk("rst_start_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_start_done", {31'h0, bus.done}, 32'h0);
    chk("rst_start_data_out", bus.data_out, 32'h0);
    @(negedge clk);
    chk("rst_start_still_idle", {31'h0, bus.busy}, 32'h0);
    repeat (8) @(negedge clk);

    // Randomised traffic, mostly back-to-back with occasional idle gaps.
    for (int t = 0; t < 2000; t++) begin
      r_op = 2'($urandom_range(0, 3));
      r_d  = $urandom();
      r_s  = 5'($urandom_range(0, 31));
      issue(r_op, r_d, r_s, ref_model(r_op, r_d, int'(r_s)), 1'b1);
      wait_done("random");
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end

    guard = 0;
    while (sb_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_shift_unit_iterative
